// File: rtl/cas_recorder.sv
// cas_recorder: SVI-328 cassette recording path.
// Samples the console's 1-bit cassette-write waveform and measures its
// half-periods on a 1 us timebase. Each half-period is classified as
// S (2400 Hz), L (1200 Hz) or GAP. The half-periods are decoded into bits:
// four S halves make a 1 and two L halves make a 0. Bits are framed into
// bytes (a 0 start bit followed by 8 data bits, LSB first) and passed
// through a small FIFO. Bytes are then written sequentially to the SDRAM
// cassette region.
//
// Optional feature macro: CAS_RECORDER_CHECKSUM_EN adds a checksum output
// holding the mod-256 sum of all acknowledged bytes.
//
// Ports:
//   clk          clk_21m3 domain clock
//   reset_n      asynchronous active-low reset
//   rec_en       record armed / motor on; edges ignored while low
//   rec_start    1-cycle synchronous clear of address, count, flags, FIFO
//   tap_in       cassette-write waveform (asynchronous)
//   sdram_addr   byte offset within the cassette region
//   sdram_data   byte to write
//   sdram_we     write request, held until sdram_ready
//   sdram_ready  1-cycle acknowledge from the SDRAM arbiter
//   byte_count   bytes committed to SDRAM
//   status       {full, overflow, frame_err}, all sticky
//   checksum     (CAS_RECORDER_CHECKSUM_EN only) sum of acknowledged bytes
module cas_recorder #(
  parameter int unsigned CLK_DIV      = 21,
  parameter int unsigned SHORT_MAX_US = 312,
  parameter int unsigned TIMEOUT_US   = 1000,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rec_en,
  input  logic        rec_start,
  input  logic        tap_in,
  output logic [20:0] sdram_addr,
  output logic [7:0]  sdram_data,
  output logic        sdram_we,
  input  logic        sdram_ready,
  output logic [20:0] byte_count,
  output logic [2:0]  status
`ifdef CAS_RECORDER_CHECKSUM_EN
  , output logic [7:0] checksum
`endif
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_DIV - 1);
  localparam logic [9:0]    US_SHORT = 10'(SHORT_MAX_US);
  localparam logic [9:0]    US_TMO   = 10'(TIMEOUT_US);
  localparam logic [9:0]    US_TMO_M1 = 10'(TIMEOUT_US - 1);

  typedef enum logic [2:0] {D_HUNT, D_S1, D_S2, D_S3, D_L1} dec_t;
  typedef enum logic       {F_IDLE, F_DATA} frm_t;

  logic          r_sync1, r_sync2, r_sync_d;
  logic [PW-1:0] r_pre;
  logic [9:0]    r_us;
  dec_t          r_dec;
  frm_t          r_frm;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wp, r_rp;
  logic          r_we;
  logic [20:0]   r_addr, r_cnt;
  logic [7:0]    r_data;
  logic          r_full, r_ovf, r_ferr;
`ifdef CAS_RECORDER_CHECKSUM_EN
  logic [7:0]    r_csum;
`endif

  logic        w_edge, w_acc, w_tick, w_tmo;
  logic        w_sym_s, w_sym_l, w_sym_g;
  dec_t        w_dec_nxt;
  logic        w_bit_v, w_bit, w_derr;
  logic        w_push;
  logic [7:0]  w_push_data;
  logic        w_empty, w_ffull, w_pop, w_wr, w_ovf;
  logic [20:0] w_cnt_nxt;

  assign w_edge = r_sync2 ^ r_sync_d;
  assign w_acc  = w_edge & rec_en;
  assign w_tick = (r_pre == PRE_MAX);
  // The timeout fires on the tick that carries the counter onto TIMEOUT_US,
  // which happens only once per silent stretch.
  assign w_tmo  = rec_en & w_tick & ~w_acc & (r_us == US_TMO_M1);

  assign w_sym_s = w_acc & (r_us < US_SHORT);
  assign w_sym_l = w_acc & (r_us >= US_SHORT) & (r_us < US_TMO);
  assign w_sym_g = (w_acc & (r_us >= US_TMO)) | w_tmo;

  always_comb begin
    w_dec_nxt = r_dec;
    w_bit_v   = 1'b0;
    w_bit     = 1'b0;
    w_derr    = 1'b0;
    case (r_dec)
      D_HUNT: begin
        if (w_sym_s)      w_dec_nxt = D_S1;
        else if (w_sym_l) w_dec_nxt = D_L1;
      end
      D_L1: begin
        if (w_sym_l) begin
          w_bit_v = 1'b1; w_dec_nxt = D_HUNT;
        end else if (w_sym_s | w_sym_g) begin
          w_derr = 1'b1; w_dec_nxt = D_HUNT;
        end
      end
      D_S1, D_S2, D_S3: begin
        if (w_sym_s) begin
          if (r_dec == D_S1)      w_dec_nxt = D_S2;
          else if (r_dec == D_S2) w_dec_nxt = D_S3;
          else begin
            w_bit_v = 1'b1; w_bit = 1'b1; w_dec_nxt = D_HUNT;
          end
        end else if (w_sym_l | w_sym_g) begin
          w_derr = 1'b1; w_dec_nxt = D_HUNT;
        end
      end
      default: w_dec_nxt = D_HUNT;
    endcase
  end

  always_comb begin
    w_push      = 1'b0;
    w_push_data = '0;
    if (rec_en && w_bit_v && r_frm == F_DATA && r_idx == 3'd7) begin
      w_push      = 1'b1;
      w_push_data = {w_bit, r_shift[7:1]};
    end
  end

  assign w_empty   = (r_wp == r_rp);
  assign w_ffull   = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_pop     = r_we & sdram_ready;
  assign w_wr      = ~rec_start & w_push & ~r_full & (~w_ffull | w_pop);
  assign w_ovf     = w_push & ~r_full & w_ffull & ~w_pop;
  assign w_cnt_nxt = r_cnt + 21'd1;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp[AW-1:0]] <= w_push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0; r_sync2 <= 1'b0; r_sync_d <= 1'b0;
      r_pre <= '0; r_us <= '0;
      r_dec <= D_HUNT; r_frm <= F_IDLE; r_idx <= '0; r_shift <= '0;
      r_wp <= '0; r_rp <= '0;
      r_we <= 1'b0; r_addr <= '0; r_cnt <= '0; r_data <= '0;
      r_full <= 1'b0; r_ovf <= 1'b0; r_ferr <= 1'b0;
`ifdef CAS_RECORDER_CHECKSUM_EN
      r_csum <= '0;
`endif
    end else begin
      r_sync1  <= tap_in;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
      if (rec_start) begin
        r_pre <= '0; r_us <= '0;
        r_dec <= D_HUNT; r_frm <= F_IDLE; r_idx <= '0; r_shift <= '0;
        r_wp <= '0; r_rp <= '0;
        r_we <= 1'b0; r_addr <= '0; r_cnt <= '0; r_data <= '0;
        r_full <= 1'b0; r_ovf <= 1'b0; r_ferr <= 1'b0;
`ifdef CAS_RECORDER_CHECKSUM_EN
        r_csum <= '0;
`endif
      end else begin
        // timebase: an accepted edge restarts the half-period measurement
        if (w_acc) begin
          r_pre <= '0; r_us <= '0;
        end else if (w_tick) begin
          r_pre <= '0;
          if (r_us != '1) r_us <= r_us + 10'd1;
        end else begin
          r_pre <= r_pre + PW'(1);
        end

        // dropping rec_en abandons any partial bit or byte silently
        if (!rec_en) begin
          r_dec <= D_HUNT;
          r_frm <= F_IDLE;
        end else begin
          r_dec <= w_dec_nxt;
          if (w_derr) r_ferr <= 1'b1;
          case (r_frm)
            F_IDLE: if (w_bit_v && !w_bit) begin
              r_frm <= F_DATA; r_idx <= '0;
            end
            F_DATA: begin
              if (w_sym_g) begin
                r_frm <= F_IDLE; r_ferr <= 1'b1;
              end else if (w_bit_v) begin
                r_shift <= {w_bit, r_shift[7:1]};
                r_idx   <= r_idx + 3'd1;
                if (r_idx == 3'd7) r_frm <= F_IDLE;
              end
            end
            default: r_frm <= F_IDLE;
          endcase
        end

        if (w_wr)  r_wp  <= r_wp + 1'b1;
        if (w_ovf) r_ovf <= 1'b1;
        if (r_full)     r_rp <= r_wp;
        else if (w_pop) r_rp <= r_rp + 1'b1;

        if (w_pop) begin
          r_we  <= 1'b0;
          r_cnt <= w_cnt_nxt;
          if (w_cnt_nxt == '1) r_full <= 1'b1;
`ifdef CAS_RECORDER_CHECKSUM_EN
          r_csum <= r_csum + r_data;
`endif
        end else if (!r_we && !w_empty && !r_full) begin
          r_we   <= 1'b1;
          r_data <= r_mem[r_rp[AW-1:0]];
          r_addr <= r_cnt;
        end
      end
    end
  end

  assign sdram_addr = r_addr;
  assign sdram_data = r_data;
  assign sdram_we   = r_we;
  assign byte_count = r_cnt;
  assign status     = {r_full, r_ovf, r_ferr};
`ifdef CAS_RECORDER_CHECKSUM_EN
  assign checksum   = r_csum;
`endif

endmodule

// File: tb/tb_cas_recorder.sv
// Directed testbench for cas_recorder. The timebase is scaled down so the
// run stays short: 2 clk per us, S < 26 us, GAP >= 84 us. Halves are sent as
// S = 17 us (34 clk) and L = 35 us (70 clk).
module tb_cas_recorder;
  localparam int unsigned DIV  = 2;
  localparam int unsigned SMAX = 26;
  localparam int unsigned TMO  = 84;
  localparam int S_CYC    = 34;
  localparam int L_CYC    = 70;
  localparam int IDLE_CYC = 200;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rec_en = 1'b0;
  logic        rec_start = 1'b0;
  logic        tap_in = 1'b0;
  logic        r_ack = 1'b0;
  logic        r_spur = 1'b0;
  logic        sdram_ready;
  logic [20:0] sdram_addr;
  logic [7:0]  sdram_data;
  logic        sdram_we;
  logic [20:0] byte_count;
  logic [2:0]  status;
`ifdef CAS_RECORDER_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  assign sdram_ready = r_ack | r_spur;

  cas_recorder #(.CLK_DIV(DIV), .SHORT_MAX_US(SMAX), .TIMEOUT_US(TMO), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .rec_en(rec_en), .rec_start(rec_start),
    .tap_in(tap_in), .sdram_addr(sdram_addr), .sdram_data(sdram_data),
    .sdram_we(sdram_we), .sdram_ready(sdram_ready), .byte_count(byte_count),
    .status(status)
`ifdef CAS_RECORDER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // SDRAM responder: acknowledges after ack_delay cycles and logs writes.
  int          ack_delay = 0;
  bit          ack_enable = 1'b1;
  int          wcnt = 0;
  bit          hold_err = 1'b0;
  logic [7:0]  held_d;
  logic [20:0] held_a;
  logic [20:0] qa[$];
  logic [7:0]  qd[$];

  always @(negedge clk) begin
    r_ack = 1'b0;
    if (sdram_we && ack_enable) begin
      if (wcnt == 0) begin
        held_d = sdram_data; held_a = sdram_addr;
      end else if (sdram_data !== held_d || sdram_addr !== held_a) begin
        hold_err = 1'b1;
      end
      if (wcnt >= ack_delay) begin
        r_ack = 1'b1;
        qa.push_back(sdram_addr);
        qd.push_back(sdram_data);
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else if (!sdram_we && wcnt != 0) begin
      hold_err = 1'b1;
      wcnt = 0;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic toggle_after(input int n);
    tick(n);
    tap_in = ~tap_in;
  endtask

  task automatic send_bit(input bit b);
    if (b) repeat (4) toggle_after(S_CYC);
    else   repeat (2) toggle_after(L_CYC);
  endtask

  // silence long enough that the first edge is a GAP, then leader 1,1 and start 0
  task automatic lead_in();
    tick(IDLE_CYC);
    tap_in = ~tap_in;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    lead_in();
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic pulse_start();
    rec_start = 1'b1;
    tick(1);
    rec_start = 1'b0;
  endtask

  task automatic wait_writes(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (qa.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, qa.size(), n);
  endtask

  initial begin
    int k;
    // reset state
    tick(3);
    check("rst_we", sdram_we, 0);
    check("rst_addr", sdram_addr, 0);
    check("rst_data", sdram_data, 0);
    check("rst_count", byte_count, 0);
    check("rst_status", status, 0);
    reset_n = 1'b1;
    rec_en  = 1'b1;
    tick(2);

    // single byte 0xA5 with latency bound after its last edge (2 sync + 3)
    send_byte(8'hA5);
    k = 0;
    while (!sdram_we && qa.size() == 0 && k < 5) begin
      tick(1);
      k++;
    end
    check("a5_latency", (sdram_we || qa.size() > 0), 1);
    wait_writes("a5_nwrites", 1, 50);
    if (qa.size() >= 1) begin
      check("a5_addr", qa[0], 0);
      check("a5_data", qd[0], 8'hA5);
    end
    tick(3);
    check("a5_count", byte_count, 1);
    check("a5_status", status, 0);
    check("a5_we_low", sdram_we, 0);

    // ready while idle is ignored
    r_spur = 1'b1;
    tick(1);
    r_spur = 1'b0;
    tick(2);
    check("spur_count", byte_count, 1);

    // three bytes with 20-cycle acknowledge delay
    pulse_start();
    check("start_count", byte_count, 0);
    qa.delete(); qd.delete();
    ack_delay = 20;
    hold_err  = 1'b0;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h3C);
    wait_writes("three_nwrites", 3, 200);
    if (qa.size() >= 3) begin
      check("three_addr0", qa[0], 0);
      check("three_data0", qd[0], 8'h00);
      check("three_addr1", qa[1], 1);
      check("three_data1", qd[1], 8'hFF);
      check("three_addr2", qa[2], 2);
      check("three_data2", qd[2], 8'h3C);
    end
    check("three_hold", hold_err, 0);
    check("three_count", byte_count, 3);
    ack_delay = 0;

    // L then S sets frame_err; next byte still lands at addr 0
    pulse_start();
    qa.delete(); qd.delete();
    tick(IDLE_CYC);
    tap_in = ~tap_in;
    toggle_after(L_CYC);
    toggle_after(S_CYC);
    tick(6);
    check("ls_status", status, 3'b001);
    send_byte(8'h12);
    wait_writes("ls_nwrites", 1, 50);
    if (qa.size() >= 1) begin
      check("ls_addr", qa[0], 0);
      check("ls_data", qd[0], 8'h12);
    end

    // overflow: five bytes with acknowledge held off
    pulse_start();
    qa.delete(); qd.delete();
    ack_enable = 1'b0;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    tick(10);
    check("ovf_status", status, 3'b010);
    check("ovf_nowrite", qa.size(), 0);
    check("ovf_we_held", sdram_we, 1);
    ack_enable = 1'b1;
    wait_writes("ovf_nwrites", 4, 100);
    tick(50);
    check("ovf_total", qa.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (qa.size() > i) begin
        check("ovf_addr", qa[i], i);
        check("ovf_data", qd[i], (i + 1) * 8'h11);
      end
    end
    check("ovf_count", byte_count, 4);

    // reset mid-byte, then 0x55 at addr 0
    lead_in();
    send_bit(1'b1);
    send_bit(1'b0);
    tap_in  = 1'b0;
    reset_n = 1'b0;
    tick(3);
    check("mrst_count", byte_count, 0);
    check("mrst_addr", sdram_addr, 0);
    reset_n = 1'b1;
    qa.delete(); qd.delete();
    send_byte(8'h55);
    wait_writes("mrst_nwrites", 1, 50);
    if (qa.size() >= 1) begin
      check("mrst_addr0", qa[0], 0);
      check("mrst_data0", qd[0], 8'h55);
    end
    tick(3);
    check("mrst_status", status, 0);

    // silence mid-byte: frame_err and no write
    lead_in();
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    tick(250);
    check("gap_status", status, 3'b001);
    check("gap_nowrite", qa.size(), 1);
    check("gap_count", byte_count, 1);

    // rec_en drop mid-byte: partial discarded silently, next byte clean
    pulse_start();
    qa.delete(); qd.delete();
    lead_in();
    send_bit(1'b1);
    send_bit(1'b0);
    rec_en = 1'b0;
    tick(20);
    rec_en = 1'b1;
    send_byte(8'hC3);
    wait_writes("en_nwrites", 1, 50);
    if (qa.size() >= 1) begin
      check("en_addr", qa[0], 0);
      check("en_data", qd[0], 8'hC3);
    end
    tick(3);
    check("en_status", status, 0);

`ifdef CAS_RECORDER_CHECKSUM_EN
    pulse_start();
    qa.delete(); qd.delete();
    send_byte(8'h80);
    send_byte(8'h90);
    wait_writes("cs_nwrites", 2, 50);
    tick(3);
    check("cs_sum", checksum, 8'h10);
    pulse_start();
    tick(1);
    check("cs_clear", checksum, 0);
    check("cs_count", byte_count, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cas_recorder.md
Name: cas_recorder

Overview:
- Tape recording path for the SVI-328 core; counterpart of the CAS playback reader.
- Samples the 1-bit cassette-write waveform produced by the console and decodes its FSK half-periods into bits, then bytes.
- Buffers decoded bytes in a small FIFO and writes them sequentially into the SDRAM cassette region, where byte offset n maps to SDRAM address {2'b11, n}.
- Runs on clk_21m3. The top level muxes the SDRAM write port to this block.

Parameters:
- CLK_DIV, 21: clk cycles per 1 µs timebase tick.
- SHORT_MAX_US, 312: a half-period strictly below this value is S (2400 Hz); a value at or above it is L (1200 Hz).
- TIMEOUT_US, 1000: a half-period at or above this value is a gap.
- FIFO_DEPTH, 4: byte FIFO depth; must be a power of 2.

Ports:
- clk  in  1  clock (clk_21m3 domain)
- reset_n  in  1  asynchronous active-low reset
- rec_en  in  1  record armed and motor on; while 0, no new edges are accepted
- rec_start  in  1  one-cycle pulse: clear address, count, flags and FIFO
- tap_in  in  1  cassette-write waveform, asynchronous to clk
- sdram_addr  out  21  byte offset within the cassette region
- sdram_data  out  8  byte to write
- sdram_we  out  1  write request
- sdram_ready  in  1  one-cycle acknowledge from the SDRAM arbiter
- byte_count  out  21  number of bytes committed to SDRAM
- status  out  3  {full, overflow, frame_err}; all bits sticky

Behaviour:
- Reset (async, reset_n=0) clears everything:
  - outputs: sdram_we=0, sdram_addr=0, sdram_data=0, byte_count=0, status=0.
  - internal: FIFO empty, decoder in HUNT, prescaler=0, µs counter=0.
- rec_start has the same effect as reset, but synchronous. It overrides every other event in the same cycle, including an sdram_ready.
- Input conditioning and timing:
  - tap_in passes through a 2-FF synchroniser. An edge is detected when the synchronised value differs from its 1-cycle delayed copy.
  - The µs counter is 10 bits, increments on each prescaler tick, and saturates at 1023.
  - On every edge while rec_en=1, the counter value is classified S, L or GAP, and the counter then restarts at 0.
  - If the counter reaches TIMEOUT_US with no edge, a GAP is generated once.
- Bit decoder states:
  - HUNT: S goes to S1. L goes to L1. GAP stays in HUNT.
  - L1: L emits bit 0 and returns to HUNT. S or GAP goes to HUNT and sets frame_err, except that GAP in HUNT never sets frame_err.
  - S1 -> S2 -> S3 on successive S. The S in S3 emits bit 1 and returns to HUNT. Any L or GAP in S1..S3 goes to HUNT and sets frame_err.
- Byte framer states:
  - IDLE: ignores 1 bits (leader and inter-byte idle). A 0 bit is the start bit and goes to DATA with the bit index at 0.
  - DATA: collects 8 bits LSB first. After the 8th bit, pushes the byte to the FIFO and returns to IDLE.
  - A GAP while in DATA discards the partial byte, sets frame_err, and returns to IDLE.
- FIFO:
  - Push when full: the byte is dropped and overflow is set.
  - Push and pop in the same cycle are both honoured.
- SDRAM write handshake:
  - When the FIFO is non-empty and full=0, sdram_we=1 with sdram_data = FIFO head and sdram_addr = byte_count.
  - sdram_we and sdram_data stay stable until sdram_ready=1.
  - On sdram_ready with sdram_we=1: pop the FIFO and increment byte_count. sdram_we drops for 1 cycle before the next request.
  - sdram_ready while sdram_we=0 is ignored.
- Region limit:
  - When byte_count reaches 2^21-1, full is set and no further writes are issued.
  - Remaining FIFO bytes are discarded. Later pushes are dropped without setting overflow.
- rec_en falling mid-byte: the partial byte is discarded without setting frame_err. Bytes already in the FIFO still drain.
- Worst-case latency from the last edge of a byte to sdram_we=1 is 3 cycles.

Optional Feature:
- Macro: CAS_RECORDER_CHECKSUM_EN.
- When defined:
  - extra output checksum[7:0] equals the modulo-256 sum of all bytes acknowledged since reset or rec_start.
  - it updates in the cycle after the sdram_ready acknowledge.
- When undefined: the port is absent and no adder is synthesised.

Test Plan:
- Byte 0xA5 sent as leader 1,1, start 0, then data bits 1,0,1,0,0,1,0,1, using S=208 µs and L=417 µs halves -> one write: addr 0, data 0xA5; byte_count=1; status=0.
- Three bytes 0x00, 0xFF, 0x3C with sdram_ready delayed 20 cycles each -> writes at addr 0, 1, 2 in order; sdram_we held high through each wait.
- Half-period sequence L then S -> frame_err=1; the next valid byte 0x12 is still written at addr 0.
- sdram_ready held low while 5 bytes are sent with FIFO_DEPTH=4 -> overflow=1; after release, 4 bytes are written and the 5th is absent.
- Assert reset_n=0 mid-byte, then send 0x55 -> address restarts at 0 and data 0x55 is written; 1100 µs of silence mid-byte -> frame_err=1 and no write.
- With CAS_RECORDER_CHECKSUM_EN: write 0x80, 0x90 -> checksum=0x10; rec_start pulse -> checksum=0 and byte_count=0.
